ascon_data_packer: RTL and testbench

ASCON_DATA_PACKER -- requirements
Module: ascon_data_packer

---
 rtl/ascon_data_packer.sv | 183 ++++++++++++++++++
 tb/tb_ascon_data_packer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ascon_data_packer.sv
// ascon_data_packer
// Packs a byte stream into 64-bit big-endian blocks for an ASCON core and
// appends the 0x80 padding byte after the last message byte. When the last
// byte completes a block, the padding goes into an extra block that is sent
// after the core has absorbed the data block.
//
// Ports
//   clock_i          single clock, rising edge
//   reset_i          synchronous, active-high reset
//   go_i             message-start request (only sampled in IDLE)
//   byte_i           plaintext byte, qualified by byte_valid_i
//   byte_valid_i     byte_i is valid
//   byte_last_i      byte_i is the final byte of the message
//   byte_ready_o     packer accepts a byte this cycle (FILL only)
//   start_o          one-cycle start pulse to the core
//   data_o           packed block to the core
//   data_valid_o     one-cycle block-valid pulse to the core
//   cipher_valid_i   core has absorbed the block
//   end_i            core has finished the tag
//   busy_o           high in every state except IDLE
//   nb_blocks_o      data_valid_o pulses issued for the current message
//   err_o            sticky block-overflow flag, cleared by the next go_i
//
// States
//   IDLE        | waiting for go_i
//   START       | start_o pulse to the core
//   FILL        | accepting bytes into data_o
//   SEND        | data_valid_o pulse, or overflow -> IDLE
//   WAIT_CIPHER | waiting for the core to absorb the block
//   WAIT_END    | waiting for the tag to complete

module ascon_data_packer #(
    parameter int unsigned MAX_BLOCKS = 15
) (
    input  logic        clock_i,
    input  logic        reset_i,
    input  logic        go_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    input  logic        byte_last_i,
    output logic        byte_ready_o,
    output logic        start_o,
    output logic [63:0] data_o,
    output logic        data_valid_o,
    input  logic        cipher_valid_i,
    input  logic        end_i,
    output logic        busy_o,
    output logic [3:0]  nb_blocks_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        FILL,
        SEND,
        WAIT_CIPHER,
        WAIT_END
    } state_t;

    state_t      state_q;
    logic [2:0]  idx_q;
    logic        final_q;
    logic        pad_q;
    logic        start_q;
    logic        dv_q;
    logic        err_q;
    logic [3:0]  nb_q;
    logic [63:0] data_q;

    logic [63:0] data_wr_d;
    logic        at_max;

    // Block count already at the limit: the next SEND must not pulse.
    assign at_max = (nb_q == 4'(MAX_BLOCKS));

    // Block contents after a byte write at idx_q. On the last byte, the
    // padding byte lands right after it and every lower byte is cleared.
    always_comb begin
        data_wr_d = data_q;
        for (int b = 0; b < 8; b++) begin
            if (3'(b) == idx_q) begin
                data_wr_d[63-8*b -: 8] = byte_i;
            end else if (byte_last_i && (b > int'(idx_q))) begin
                data_wr_d[63-8*b -: 8] = (b == int'(idx_q) + 1) ? 8'h80 : 8'h00;
            end
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            idx_q   <= 3'd0;
            final_q <= 1'b0;
            pad_q   <= 1'b0;
            start_q <= 1'b0;
            dv_q    <= 1'b0;
            err_q   <= 1'b0;
            nb_q    <= 4'd0;
            data_q  <= 64'd0;
        end else begin
            start_q <= 1'b0;
            dv_q    <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (go_i) begin
                        state_q <= START;
                        start_q <= 1'b1;
                        nb_q    <= 4'd0;
                        err_q   <= 1'b0;
                        idx_q   <= 3'd0;
                        final_q <= 1'b0;
                        pad_q   <= 1'b0;
                    end
                end
                START: begin
                    state_q <= FILL;
                end
                FILL: begin
                    if (byte_valid_i) begin
                        data_q <= data_wr_d;
                        idx_q  <= idx_q + 3'd1;
                        if (byte_last_i) begin
                            // A full last block leaves no room for padding.
                            if (idx_q == 3'd7) begin
                                pad_q <= 1'b1;
                            end else begin
                                final_q <= 1'b1;
                            end
                            state_q <= SEND;
                            dv_q    <= !at_max;
                        end else if (idx_q == 3'd7) begin
                            state_q <= SEND;
                            dv_q    <= !at_max;
                        end
                    end
                end
                SEND: begin
                    if (at_max) begin
                        err_q   <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        nb_q    <= nb_q + 4'd1;
                        state_q <= WAIT_CIPHER;
                    end
                end
                WAIT_CIPHER: begin
                    if (cipher_valid_i) begin
                        if (final_q) begin
                            state_q <= WAIT_END;
                        end else if (pad_q) begin
                            data_q  <= 64'h8000_0000_0000_0000;
                            final_q <= 1'b1;
                            pad_q   <= 1'b0;
                            state_q <= SEND;
                            dv_q    <= !at_max;
                        end else begin
                            idx_q   <= 3'd0;
                            state_q <= FILL;
                        end
                    end
                end
                WAIT_END: begin
                    if (end_i) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign byte_ready_o = (state_q == FILL);
    assign busy_o       = (state_q != IDLE);
    assign start_o      = start_q;
    assign data_valid_o = dv_q;
    assign data_o       = data_q;
    assign nb_blocks_o  = nb_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_ascon_data_packer.sv
module tb_ascon_data_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic [7:0]  byte_v = 8'd0;
    logic        valid = 1'b0;
    logic        last = 1'b0;
    logic        cipher_v = 1'b0;
    logic        end_v = 1'b0;
    bit          sel_r = 1'b0;

    logic        ready_a, start_a, dv_a, busy_a, err_a;
    logic [63:0] data_a;
    logic [3:0]  nb_a;
    logic        ready_b, start_b, dv_b, busy_b, err_b;
    logic [63:0] data_b;
    logic [3:0]  nb_b;
    logic        go_a, go_b;

    logic        ready_m, start_m, dv_m, busy_m, err_m;
    logic [63:0] data_m;
    logic [3:0]  nb_m;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [63:0] exp_q[$];
    int          dv_cnt = 0;
    int          blocks_expected = 0;
    bit          in_wait = 1'b0;

    always #5 clk = ~clk;

    assign go_a = go & ~sel_r;
    assign go_b = go & sel_r;

    ascon_data_packer #(.MAX_BLOCKS(15)) dut_a (
        .clock_i(clk), .reset_i(rst), .go_i(go_a), .byte_i(byte_v),
        .byte_valid_i(valid), .byte_last_i(last), .byte_ready_o(ready_a),
        .start_o(start_a), .data_o(data_a), .data_valid_o(dv_a),
        .cipher_valid_i(cipher_v), .end_i(end_v), .busy_o(busy_a),
        .nb_blocks_o(nb_a), .err_o(err_a)
    );

    ascon_data_packer #(.MAX_BLOCKS(1)) dut_b (
        .clock_i(clk), .reset_i(rst), .go_i(go_b), .byte_i(byte_v),
        .byte_valid_i(valid), .byte_last_i(last), .byte_ready_o(ready_b),
        .start_o(start_b), .data_o(data_b), .data_valid_o(dv_b),
        .cipher_valid_i(cipher_v), .end_i(end_v), .busy_o(busy_b),
        .nb_blocks_o(nb_b), .err_o(err_b)
    );

    assign ready_m = sel_r ? ready_b : ready_a;
    assign start_m = sel_r ? start_b : start_a;
    assign dv_m    = sel_r ? dv_b    : dv_a;
    assign busy_m  = sel_r ? busy_b  : busy_a;
    assign err_m   = sel_r ? err_b   : err_a;
    assign data_m  = sel_r ? data_b  : data_a;
    assign nb_m    = sel_r ? nb_b    : nb_a;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference packing: bytes base, base+1, ... then 0x80 then zeros.
    function automatic logic [63:0] model_block(int n, logic [7:0] base, int k);
        logic [63:0] blk;
        int          pos;
        blk = 64'd0;
        for (int j = 0; j < 8; j++) begin
            pos = 8 * k + j;
            if (pos < n)       blk[63-8*j -: 8] = 8'(int'(base) + pos);
            else if (pos == n) blk[63-8*j -: 8] = 8'h80;
        end
        return blk;
    endfunction

    // Scoreboard: every data_valid pulse must match the next expected block.
    always @(negedge clk) begin
        if (dv_m) begin
            if (exp_q.size() == 0) begin
                check("unexpected_data_valid", 64'd1, 64'd0);
            end else begin
                check("data_block", data_m, exp_q.pop_front());
            end
        end
        if (in_wait) check("ready_low_while_waiting", {63'd0, ready_m}, 64'd0);
        if (dv_m) in_wait = 1'b1;
        if (cipher_v || rst) in_wait = 1'b0;
    end

    // Core model: absorbs each block a few cycles later and ends the tag
    // after the last block of a message that fits.
    initial begin
        forever begin
            @(negedge clk);
            if (dv_m && !rst) begin
                dv_cnt++;
                repeat (3) @(posedge clk);
                #1 cipher_v = 1'b1;
                @(posedge clk);
                #1 cipher_v = 1'b0;
                if (dv_cnt == blocks_expected) begin
                    repeat (2) @(posedge clk);
                    #1 end_v = 1'b1;
                    @(posedge clk);
                    #1 end_v = 1'b0;
                end
            end
        end
    end

    // Called #1 after a rising edge; returns once the byte is accepted.
    task automatic send_byte(input logic [7:0] b, input logic l, output bit ok);
        bit r;
        ok     = 1'b0;
        byte_v = b;
        last   = l;
        valid  = 1'b1;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            r = ready_m;
            @(posedge clk);
            #1;
            if (r) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("byte_accept_timeout", 64'd1, 64'd0);
    endtask

    task automatic pulse_go();
        @(posedge clk);
        #1 go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        @(negedge clk);
        check("start_pulse", {63'd0, start_m}, 64'd1);
        check("err_cleared_on_go", {63'd0, err_m}, 64'd0);
        check("nb_cleared_on_go", {60'd0, nb_m}, 64'd0);
        @(posedge clk);
        #1;
        check("start_one_cycle", {63'd0, start_m}, 64'd0);
    endtask

    task automatic run_msg(input bit sel, input int n, input logic [7:0] base,
                           input int exp_nb, input bit exp_err);
        int  maxb, blocks, nemit;
        bit  ok;
        sel_r  = sel;
        maxb   = sel ? 1 : 15;
        blocks = n / 8 + 1;
        nemit  = (blocks < maxb) ? blocks : maxb;
        blocks_expected = (blocks <= maxb) ? blocks : 0;
        dv_cnt = 0;
        for (int k = 0; k < nemit; k++) exp_q.push_back(model_block(n, base, k));
        pulse_go();
        for (int i = 0; i < n; i++) begin
            send_byte(8'(int'(base) + i), (i == n - 1), ok);
            if (!ok) break;
        end
        valid = 1'b0;
        last  = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (!busy_m) break;
        end
        check("busy_low_at_end", {63'd0, busy_m}, 64'd0);
        check("nb_blocks", {60'd0, nb_m}, 64'(exp_nb));
        check("err_flag", {63'd0, err_m}, {63'd0, exp_err});
        check("pulse_count", 64'(dv_cnt), 64'(exp_nb));
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
    endtask

    typedef struct {
        bit         sel;
        int         nbytes;
        logic [7:0] base;
        int         exp_nb;
        bit         exp_err;
    } vec_t;

    vec_t vecs[13];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        vecs[0]  = '{1'b0,   3, 8'h01,  1, 1'b0};
        vecs[1]  = '{1'b0,   8, 8'h11,  2, 1'b0};
        vecs[2]  = '{1'b0,  12, 8'hA0,  2, 1'b0};
        vecs[3]  = '{1'b0,   1, 8'h55,  1, 1'b0};
        vecs[4]  = '{1'b0,   7, 8'h30,  1, 1'b0};
        vecs[5]  = '{1'b0,  15, 8'h40,  2, 1'b0};
        vecs[6]  = '{1'b0,  16, 8'h60,  3, 1'b0};
        vecs[7]  = '{1'b0, 119, 8'h00, 15, 1'b0};
        vecs[8]  = '{1'b0, 120, 8'h00, 15, 1'b1};
        vecs[9]  = '{1'b1,   9, 8'h70,  1, 1'b1};
        vecs[10] = '{1'b1,   3, 8'h90,  1, 1'b0};
        vecs[11] = '{1'b1,   8, 8'hB0,  1, 1'b1};
        vecs[12] = '{1'b1,   7, 8'hC0,  1, 1'b0};

        // Reset state of both instances.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_a_outputs", {data_a, 1'b0}, 65'd0);
        check("rst_a_flags", {57'd0, ready_a, start_a, dv_a, busy_a, err_a, nb_a == 4'd0 ? 1'b0 : 1'b1, 1'b0}, 64'd0);
        check("rst_b_outputs", data_b, 64'd0);
        check("rst_b_flags", {57'd0, ready_b, start_b, dv_b, busy_b, err_b, nb_b}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // First message must pack 0x01..0x03 into one padded block.
        check("req_first_block_model", model_block(3, 8'h01, 0), 64'h0102_0380_0000_0000);

        for (int i = 0; i < 13; i++) begin
            run_msg(vecs[i].sel, vecs[i].nbytes, vecs[i].base, vecs[i].exp_nb, vecs[i].exp_err);
        end

        // go while busy is ignored, then reset mid-message wins over all inputs.
        sel_r = 1'b0;
        blocks_expected = 0;
        dv_cnt = 0;
        pulse_go();
        go = 1'b1;
        @(posedge clk);
        #1 go = 1'b0;
        check("go_ignored_while_busy", {62'd0, start_m, busy_m}, 64'd1);
        for (int i = 0; i < 5; i++) begin
            send_byte(8'(8'hE0 + i), 1'b0, ok);
        end
        check("partial_block_bytes", data_m[63:24], 40'hE0E1_E2E3_E4);
        rst = 1'b1;
        go  = 1'b1;
        cipher_v = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_data", data_a, 64'd0);
        check("mid_rst_flags", {57'd0, ready_a, start_a, dv_a, busy_a, err_a, nb_a != 4'd0, 1'b0}, 64'd0);
        check("mid_rst_nb", {60'd0, nb_a}, 64'd0);
        rst = 1'b0;
        go  = 1'b0;
        cipher_v = 1'b0;
        valid = 1'b0;
        run_msg(1'b0, 2, 8'hCC, 1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
